// File: rtl/therm_pkg.sv
// -----------------------------------------------------------------------------
// therm_pkg
// Shared definitions for the thermometer sampling controller.
//   state_e  : controller FSM states
//   THERM_W  : width of the comparator thermometer code
//   BIN_W    : width of the binary code derived from it
// -----------------------------------------------------------------------------
package therm_pkg;

    localparam int THERM_W = 7;
    localparam int BIN_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage : therm_pkg

// File: rtl/therm_count.sv
// -----------------------------------------------------------------------------
// therm_count
// Combinational thermometer-to-binary converter with bubble detection.
//   i_therm  : thermometer code, bit 0 lowest
//   o_count  : highest index k (1..7) with i_therm[k-1]=1, else 0
//   o_bubble : a 0 bit exists below the highest 1 bit
// -----------------------------------------------------------------------------
module therm_count
    import therm_pkg::*;
(
    input  logic [THERM_W-1:0] i_therm,
    output logic [BIN_W-1:0]   o_count,
    output logic               o_bubble
);

    logic [THERM_W-1:0] w_mask;

    // Highest set bit wins, so a bubbled code still reports its top level.
    always_comb begin
        o_count = '0;
        for (int k = 0; k < THERM_W; k++) begin
            if (i_therm[k]) begin
                o_count = BIN_W'(k + 1);
            end
        end
    end

    // Ideal code for the detected level; any difference is a bubble.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < THERM_W; k++) begin
            if (BIN_W'(k) < o_count) begin
                w_mask[k] = 1'b1;
            end
        end
        o_bubble = (i_therm != w_mask);
    end

endmodule : therm_count

// File: rtl/therm_sample_ctrl.sv
// -----------------------------------------------------------------------------
// therm_sample_ctrl
// Strobes a thermometer encoder 2^AVG_LOG2 times with a programmable gap,
// averages the converted samples and hands the rounded result to a consumer.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i, stop_i : begin acquisition (IDLE only) / abort from any state
//   cont_i          : re-arm automatically after each accepted result
//   period_i        : idle cycles between strobes, latched at start
//   thermometer_i   : comparator thermometer code
//   ready_i         : consumer accepts code_o while valid_o is high
//   clr_err_i       : clears bubble_o
//   sample_en_o     : one-cycle strobe to the encoder
//   code_o, valid_o : averaged result and its qualifier
//   busy_o          : FSM not idle
//   bubble_o        : sticky bubbled-sample flag
// -----------------------------------------------------------------------------
module therm_sample_ctrl
    import therm_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int PER_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               cont_i,
    input  logic [PER_W-1:0]   period_i,
    input  logic [THERM_W-1:0] thermometer_i,
    input  logic               ready_i,
    input  logic               clr_err_i,
    output logic               sample_en_o,
    output logic [BIN_W-1:0]   code_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               bubble_o
);

    localparam int ACC_W = BIN_W + AVG_LOG2;
    localparam int N_W   = AVG_LOG2 + 1;

    localparam logic [N_W-1:0] NSAMP   = N_W'(2 ** AVG_LOG2);
    localparam logic [ACC_W:0] HALF    = (ACC_W + 1)'((2 ** AVG_LOG2) / 2);
    localparam logic [ACC_W:0] MAXCODE = (ACC_W + 1)'((2 ** BIN_W) - 1);

    state_e             r_state;
    logic [PER_W-1:0]   r_per;
    logic [PER_W-1:0]   r_wait;
    logic [N_W-1:0]     r_nsamp;
    logic [ACC_W-1:0]   r_acc;
    logic [BIN_W-1:0]   r_code;
    logic               r_bubble;

    logic [BIN_W-1:0]   w_count;
    logic               w_bubble;
    logic [ACC_W-1:0]   w_acc_sum;

    // Round-half-up average, clamped to the code range. HALF is 0 when
    // AVG_LOG2 is 0, which makes this a plain pass-through of the sum.
    function automatic logic [BIN_W-1:0] round_sat(input logic [ACC_W-1:0] sum);
        logic [ACC_W:0] v;
        v = {1'b0, sum} + HALF;
        v = v >> AVG_LOG2;
        if (v > MAXCODE) begin
            return BIN_W'(MAXCODE);
        end
        return v[BIN_W-1:0];
    endfunction

    therm_count u_count (
        .i_therm  (thermometer_i),
        .o_count  (w_count),
        .o_bubble (w_bubble)
    );

    assign w_acc_sum = r_acc + ACC_W'(w_count);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_per   <= '0;
            r_wait  <= '0;
            r_nsamp <= '0;
            r_acc   <= '0;
            r_code  <= '0;
        end else if (stop_i) begin
            // Abort: partial sum is discarded, last result stays visible.
            r_state <= ST_IDLE;
            r_wait  <= '0;
            r_nsamp <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_per   <= period_i;
                        r_acc   <= '0;
                        r_nsamp <= NSAMP;
                        if (period_i == '0) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_state <= ST_WAIT;
                            r_wait  <= period_i - PER_W'(1);
                        end
                    end
                end
                // Loaded with per-1 and leaves after reaching 0: per cycles.
                ST_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_wait <= r_wait - PER_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_acc   <= w_acc_sum;
                    r_nsamp <= r_nsamp - N_W'(1);
                    if (r_nsamp == N_W'(1)) begin
                        r_state <= ST_DONE;
                        r_code  <= round_sat(w_acc_sum);
                    end else if (r_per == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_state <= ST_WAIT;
                        r_wait  <= r_per - PER_W'(1);
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        if (cont_i) begin
                            r_acc   <= '0;
                            r_nsamp <= NSAMP;
                            if (r_per == '0) begin
                                r_state <= ST_SAMPLE;
                            end else begin
                                r_state <= ST_WAIT;
                                r_wait  <= r_per - PER_W'(1);
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flag; a new bubble outranks a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bubble <= 1'b0;
        end else if ((r_state == ST_SAMPLE) && w_bubble) begin
            r_bubble <= 1'b1;
        end else if (clr_err_i) begin
            r_bubble <= 1'b0;
        end
    end

    assign sample_en_o = (r_state == ST_SAMPLE);
    assign valid_o     = (r_state == ST_DONE);
    assign busy_o      = (r_state != ST_IDLE);
    assign code_o      = r_code;
    assign bubble_o    = r_bubble;

endmodule : therm_sample_ctrl

// File: tb/tb_therm_sample_ctrl.sv
// -----------------------------------------------------------------------------
// tb_therm_sample_ctrl
// Directed-vector bench for therm_sample_ctrl with AVG_LOG2=2, PER_W=8.
// -----------------------------------------------------------------------------
module tb_therm_sample_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] period;
    logic [6:0] therm;
    logic       ready;
    logic       clr_err;
    logic       sample_en;
    logic [2:0] code;
    logic       valid;
    logic       busy;
    logic       bubble;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] therm_seq [4];

    therm_sample_ctrl #(
        .AVG_LOG2 (2),
        .PER_W    (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .stop_i        (stop),
        .cont_i        (cont),
        .period_i      (period),
        .thermometer_i (therm),
        .ready_i       (ready),
        .clr_err_i     (clr_err),
        .sample_en_o   (sample_en),
        .code_o        (code),
        .valid_o       (valid),
        .busy_o        (busy),
        .bubble_o      (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seq(input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] d);
        therm_seq[0] = a;
        therm_seq[1] = b;
        therm_seq[2] = c;
        therm_seq[3] = d;
        therm = a;
    endtask

    // Steps until valid, logging strobe cycle indices (0 = current cycle)
    // and presenting the next sequence entry during each strobe cycle.
    task automatic run_acq(input int budget, output int nstb,
                           output int first, output int last);
        nstb  = 0;
        first = -1;
        last  = -1;
        for (int i = 0; i < budget; i++) begin
            if (valid) return;
            if (sample_en) begin
                if (nstb == 0) first = i;
                last  = i;
                therm = therm_seq[(nstb < 4) ? nstb : 3];
                nstb++;
            end
            tick();
        end
        check("acq_timeout", 0, 1);
    endtask

    task automatic do_start(input logic [7:0] per);
        period = per;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        int nstb, first, last, cnt, chg;

        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        cont    = 1'b0;
        period  = 8'd0;
        therm   = 7'd0;
        ready   = 1'b0;
        clr_err = 1'b0;

        // Reset values
        repeat (2) tick();
        check("rst_sample_en", sample_en, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bubble", bubble, 0);
        check("rst_code", code, 0);
        rst_n = 1'b1;
        tick();

        // Basic acquisition, period 3, all samples = 5
        set_seq(7'b0011111, 7'b0011111, 7'b0011111, 7'b0011111);
        do_start(8'd3);
        check("t1_busy", busy, 1);
        run_acq(100, nstb, first, last);
        check("t1_nstrobe", nstb, 4);
        check("t1_first", first, 3);
        check("t1_span", last - first, 12);
        check("t1_valid", valid, 1);
        check("t1_code", code, 5);
        check("t1_bubble", bubble, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t1_valid_drop", valid, 0);
        check("t1_idle", busy, 0);
        check("t1_code_hold", code, 5);

        // Back-to-back strobes, samples 3,4,4,5 -> 4
        set_seq(7'b0000111, 7'b0001111, 7'b0001111, 7'b0011111);
        do_start(8'd0);
        check("t2_strobe_now", sample_en, 1);
        run_acq(100, nstb, first, last);
        check("t2_nstrobe", nstb, 4);
        check("t2_first", first, 0);
        check("t2_last", last, 3);
        check("t2_code", code, 4);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t2_idle", busy, 0);

        // Bubbled samples 0010111 -> counted as 5, sticky flag
        set_seq(7'b0010111, 7'b0010111, 7'b0010111, 7'b0010111);
        do_start(8'd0);
        run_acq(100, nstb, first, last);
        check("t3_code", code, 5);
        check("t3_bubble", bubble, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat (3) tick();
        check("t3_bubble_held", bubble, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_bubble_clr", bubble, 0);
        therm = 7'b0011111;
        do_start(8'd3);
        repeat (3) tick();
        check("t3_strobe", sample_en, 1);
        therm   = 7'b0010111;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_set_wins", bubble, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_bubble_clr2", bubble, 0);

        // Stop in WAIT after 2 of 4 samples
        therm = 7'b0011111;
        do_start(8'd3);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (sample_en) cnt++;
            tick();
        end
        check("t4_two_strobes", cnt, 2);
        check("t4_in_wait", sample_en, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4_stop_busy", busy, 0);
        check("t4_stop_valid", valid, 0);
        check("t4_stop_code", code, 5);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (sample_en || valid) cnt++;
            tick();
        end
        check("t4_quiet", cnt, 0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t4_start_stop", busy, 0);

        // Continuous mode with consumer stalled
        cont = 1'b1;
        set_seq(7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
        do_start(8'd1);
        run_acq(100, nstb, first, last);
        check("t5_code", code, 1);
        cnt = 0;
        chg = 0;
        for (int i = 0; i < 10; i++) begin
            if (sample_en) cnt++;
            if (code != 3'd1) chg++;
            tick();
        end
        check("t5_hold_strobes", cnt, 0);
        check("t5_hold_code", chg, 0);
        check("t5_hold_valid", valid, 1);
        period = 8'd9;
        set_seq(7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t5_rearm_valid", valid, 0);
        check("t5_rearm_busy", busy, 1);
        run_acq(100, nstb, first, last);
        check("t5_nstrobe", nstb, 4);
        check("t5_first", first, 1);
        check("t5_last", last, 7);
        check("t5_code2", code, 6);
        cont  = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t5_idle", busy, 0);

        // Asynchronous reset during SAMPLE
        set_seq(7'b0010111, 7'b0010111, 7'b0010111, 7'b0010111);
        do_start(8'd0);
        check("t6_in_sample", sample_en, 1);
        tick();
        check("t6_bubble_pre", bubble, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_sample_en", sample_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_code", code, 0);
        check("t6_rst_bubble", bubble, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sample_en) cnt++;
        end
        check("t6_no_strobe_in_rst", cnt, 0);
        rst_n = 1'b1;
        tick();
        check("t6_idle_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_therm_sample_ctrl

// File: doc/therm_sample_ctrl.md
THERM_SAMPLE_CTRL -- requirements
Module: therm_sample_ctrl

Interface
REQ-001 Parameter AVG_LOG2, default 2, log2 of samples averaged per result; legal range 0..4.
REQ-002 Parameter PER_W, default 8, width of the sample-period field.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  begin an acquisition; honoured only in IDLE.
REQ-006 stop_i  input  1  abort; forces IDLE from any state.
REQ-007 cont_i  input  1  continuous mode: re-arm automatically after each result is taken.
REQ-008 period_i  input  PER_W  idle cycles between strobes; latched when start_i is accepted.
REQ-009 thermometer_i  input  7  comparator thermometer code, bit 0 lowest.
REQ-010 ready_i  input  1  consumer accepts code_o when valid_o is high.
REQ-011 clr_err_i  input  1  clears bubble_o.
REQ-012 sample_en_o  output  1  one-cycle strobe to the thermometer encoder.
REQ-013 code_o  output  3  averaged binary code.
REQ-014 valid_o  output  1  code_o holds a result.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 bubble_o  output  1  sticky flag: a bubbled code was sampled.

Function
REQ-017 FSM states: IDLE, WAIT, SAMPLE, DONE.
REQ-018 IDLE + start_i (stop_i low): latch period_i into per_q, clear accumulator, load sample counter with 2^AVG_LOG2; go to SAMPLE if per_q==0, else WAIT with countdown = per_q-1.
REQ-019 WAIT: decrement countdown each cycle; at 0 go to SAMPLE; WAIT therefore lasts exactly per_q cycles.
REQ-020 SAMPLE: sample_en_o=1 for that cycle only; thermometer_i captured on the edge ending the cycle.
REQ-021 Per-sample value = highest index k (1..7) with thermometer_i[k-1]=1, else 0.
REQ-022 Bubble = any 0 bit below the highest 1 bit; sampling a bubble sets bubble_o on the next edge.
REQ-023 Consecutive strobes within one acquisition are exactly per_q+1 cycles apart.
REQ-024 After the last sample go to DONE; otherwise SAMPLE if per_q==0, else WAIT reloaded with per_q-1.
REQ-025 Accumulator width 3+AVG_LOG2, no overflow possible.
REQ-026 Result = (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2, saturated at 7; for AVG_LOG2=0, result = sum.
REQ-027 DONE: valid_o=1; code_o stable until valid_o && ready_i.
REQ-028 On handshake: cont_i=1 -> re-arm exactly as in REQ-018, keeping the latched per_q; cont_i=0 -> IDLE.
REQ-029 valid_o drops on the edge that completes the handshake.
REQ-030 code_o holds its last value after the handshake.
REQ-031 stop_i has priority over every transition, including a same-cycle start_i or handshake.
REQ-032 stop_i effect on the next edge: IDLE, valid_o=0, accumulator discarded, code_o unchanged.
REQ-033 clr_err_i clears bubble_o; a same-cycle bubble set wins over the clear.
REQ-034 start_i outside IDLE is ignored.
REQ-035 period_i changes after start_i is accepted have no effect.

Reset
REQ-036 Reset values: state IDLE, sample_en_o=0, valid_o=0, busy_o=0, bubble_o=0, code_o=0, counters=0, accumulator=0.
REQ-037 Reset asserted mid-acquisition aborts immediately; no strobe is issued while rst_ni is low.

Structure
REQ-038 Shared package therm_pkg holds the FSM state enum, THERM_W=7 and BIN_W=3.
REQ-039 Sub-module therm_count: combinational 7-bit thermometer -> 3-bit count plus bubble flag; one instance.

Verification
REQ-040 AVG_LOG2=2, period_i=3, thermometer_i=7'b0011111, cont_i=0 -> 4 strobes 4 cycles apart; then valid_o=1, code_o=5, bubble_o=0; return to IDLE after the ready_i handshake.
REQ-041 period_i=0 -> back-to-back strobes; samples 3,4,4,5 (sum 16) -> code_o=4.
REQ-042 Sample 7'b0010111 -> counted as 5, bubble_o=1 and held; clr_err_i pulse -> bubble_o=0; clr_err_i in the same cycle as a new bubble -> bubble_o stays 1.
REQ-043 stop_i asserted in WAIT after 2 of 4 samples -> IDLE next edge, no valid_o, busy_o=0; same-cycle start_i and stop_i in IDLE -> stays IDLE.
REQ-044 cont_i=1 with ready_i held low for 10 cycles -> code_o stable and no strobes; ready_i=1 -> new acquisition begins per REQ-028.
REQ-045 rst_ni pulled low during SAMPLE -> all outputs take their REQ-036 values asynchronously.
